// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised multi-cycle CPU core (FETCH/EXEC/WB) with zero/carry
// flags, JMP/JZ/MOV/HALT and a program-load port usable while idle or halted.
module cpu_core_p #(
  parameter int DW    = 6,
  parameter int RA_W  = 3,
  parameter int IM_AW = 3,
  localparam int IW   = 4 + 2*RA_W + DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [IM_AW-1:0] prog_addr,
  input  logic [IW-1:0]    prog_data,
  input  logic             run,
  input  logic [RA_W-1:0]  dbg_ra,
  output logic [DW-1:0]    dbg_rd,
  output logic [IM_AW-1:0] pc,
  output logic [1:0]       state,
  output logic             halted,
  output logic [DW-1:0]    result,
  output logic             zf,
  output logic             cf
);
  localparam int NR = 2**RA_W;
  localparam int NI = 2**IM_AW;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_JZ   = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             halted_q, halted_d;
  logic [IM_AW-1:0] pc_q, pc_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [DW-1:0]    alu_q, alu_d;
  logic             carry_q, carry_d;
  logic [DW-1:0]    result_q, result_d;
  logic             zf_q, zf_d;
  logic             cf_q, cf_d;
  logic [DW-1:0]    regs_q [NR];
  logic [IW-1:0]    imem_q [NI];
  logic             reg_we;
  logic             imem_we;

  logic [2:0]       op;
  logic             imm_sel;
  logic [RA_W-1:0]  rd, rs;
  logic [DW-1:0]    imm, opa, opb, alu_res;
  logic             alu_c;
  logic [DW:0]      sum_ext, diff_ext;
  logic [IM_AW-1:0] pc_inc, jmp_tgt;

  assign op       = ir_q[IW-1 -: 3];
  assign imm_sel  = ir_q[IW-4];
  assign rd       = ir_q[IW-5 -: RA_W];
  assign rs       = ir_q[IW-5-RA_W -: RA_W];
  assign imm      = ir_q[DW-1:0];
  assign opa      = regs_q[rd];
  assign opb      = imm_sel ? imm : regs_q[rs];
  assign sum_ext  = {1'b0, opa} + {1'b0, opb};
  assign diff_ext = {1'b0, opa} - {1'b0, opb};
  assign pc_inc   = pc_q + IM_AW'(1);
  assign jmp_tgt  = imm[IM_AW-1:0];

  // Top bit of the extended difference is the borrow (A < B).
  always_comb begin
    alu_res = opb;
    alu_c   = cf_q;
    case (op)
      OP_ADD:  begin alu_res = sum_ext[DW-1:0];  alu_c = sum_ext[DW];  end
      OP_SUB:  begin alu_res = diff_ext[DW-1:0]; alu_c = diff_ext[DW]; end
      OP_AND:  begin alu_res = opa & opb;        alu_c = 1'b0;         end
      OP_OR:   begin alu_res = opa | opb;        alu_c = 1'b0;         end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    alu_d    = alu_q;
    carry_d  = carry_q;
    result_d = result_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    reg_we   = 1'b0;
    imem_we  = prog_we && (state_q == S_IDLE);
    case (state_q)
      S_IDLE: if (!halted_q && run) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = imem_q[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_JMP: begin
            pc_d    = jmp_tgt;
            state_d = run ? S_FETCH : S_IDLE;
          end
          OP_JZ: begin
            pc_d    = zf_q ? jmp_tgt : pc_inc;
            state_d = run ? S_FETCH : S_IDLE;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_IDLE;
          end
          default: begin
            alu_d   = alu_res;
            carry_d = alu_c;
            state_d = S_WB;
          end
        endcase
      end
      S_WB: begin
        reg_we   = 1'b1;
        result_d = alu_q;
        zf_d     = (alu_q == '0);
        cf_d     = carry_q;
        pc_d     = pc_inc;
        state_d  = run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
      pc_q     <= '0;
      ir_q     <= '0;
      alu_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      alu_q    <= alu_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[rd] <= alu_q;
    end
  end

  // Program memory survives reset on purpose: a reset re-runs the loaded program.
  always_ff @(posedge clk) begin
    if (imem_we) imem_q[prog_addr] <= prog_data;
  end

  assign dbg_rd = regs_q[dbg_ra];
  assign pc     = pc_q;
  assign state  = state_q;
  assign halted = halted_q;
  assign result = result_q;
  assign zf     = zf_q;
  assign cf     = cf_q;
endmodule
